dm_arbiter: RTL

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
//   Two-requester arbiter for a single-ported data memory. Requester 0 is the
//   CPU and requester 1 is the DMA engine. It arbitrates in IDLE, runs a
//   one-cycle ACCESS, and for reads waits RD_LAT cycles before returning the
//   data. Simultaneous requests are resolved round-robin. After reset,
//   requester 0 wins the first tie.
//
// Parameters
//   AW      word-address width (byte address bits [AW+1:2])
//   DW      data width
//   RD_LAT  memory read latency in cycles, 1..3
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req0/req1         access requests (held until the matching gnt)
//   we0/we1           1 = write, 0 = read
//   addr0/addr1       word addresses
//   wdata0/wdata1     write data
//   gnt0/gnt1         one-cycle grant pulse, coincident with the memory strobe
//   rvalid0/rvalid1   one-cycle read-data-valid pulse
//   rdata0/rdata1     per-requester read data, held until that requester's
//                     next read completes
//   busy              high whenever the arbiter is not IDLE
//   dm_we/dm_read     memory write / read strobes
//   dm_addr, dm_in_d  memory address and write data, held between accesses
//   dm_out_d          memory read data
// ---------------------------------------------------------------------------
module dm_arbiter #(
  parameter int AW     = 10,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          dm_we,
  output logic          dm_read,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_in_d,
  input  logic [DW-1:0] dm_out_d
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT
  } state_t;

  // Value of the wait counter on the last WAIT cycle.
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  state_t      state;
  state_t      state_nx;

  logic        win;        // requester owning the current access
  logic        last;       // most recently granted requester
  logic        lat_we;     // latched direction of the current access
  logic [1:0]  wait_cnt;   // WAIT cycles already spent
  logic        pick;       // arbitration result for this IDLE edge
  logic        any_req;
  logic        pick_we;
  logic        wait_done;

  assign any_req   = req0 | req1;
  // On a tie, the requester that was not granted most recently wins.
  assign pick      = (req0 & req1) ? ~last : req1;
  assign pick_we   = pick ? we1 : we0;
  assign wait_done = (wait_cnt == WAIT_LAST);

  // Next state and strobes. Grants and strobes are decoded from the state
  // register, so an asynchronous reset drops them without waiting for a clock.
  always_comb begin
    state_nx = state;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    dm_we    = 1'b0;
    dm_read  = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_req) state_nx = ACCESS;
      end
      ACCESS: begin
        gnt0     = ~win;
        gnt1     = win;
        dm_we    = lat_we;
        dm_read  = ~lat_we;
        state_nx = lat_we ? IDLE : WAIT;
      end
      WAIT: begin
        if (wait_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      win      <= 1'b0;
      last     <= 1'b1;
      lat_we   <= 1'b0;
      wait_cnt <= '0;
      dm_addr  <= '0;
      dm_in_d  <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      state   <= state_nx;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;

      // Requests are sampled only in IDLE; the address and write data go
      // straight into the memory-facing registers, which then hold until the
      // next grant.
      if (state == IDLE && any_req) begin
        win     <= pick;
        last    <= pick;
        lat_we  <= pick_we;
        dm_addr <= pick ? addr1 : addr0;
        if (pick_we) dm_in_d <= pick ? wdata1 : wdata0;
      end

      if (state == ACCESS) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 2'd1;
      end

      // Capture on the edge that ends the final WAIT cycle; rvalid follows
      // in the IDLE cycle after it.
      if (state == WAIT && wait_done) begin
        if (win) begin
          rdata1  <= dm_out_d;
          rvalid1 <= 1'b1;
        end else begin
          rdata0  <= dm_out_d;
          rvalid0 <= 1'b1;
        end
      end
    end
  end

endmodule
